// File: rtl/regfile_2r1w_sp_pkg.sv
// Shared types and default parameters for the 2-read/1-write register file
// with its dedicated stack-pointer register.
package regfile_2r1w_sp_pkg;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_RSVD = 2'b11
  } sp_op_e;

  localparam int          DEF_DATA_W   = 8;
  localparam int          DEF_ADDR_W   = 5;
  localparam int          DEF_SP_IDX   = 29;
  localparam logic [7:0]  DEF_SP_RESET = 8'hFF;
  localparam logic [7:0]  DEF_SP_LIMIT = 8'h00;

endpackage

// File: rtl/regfile_2r1w_sp_if.sv
// Operand/write-back/stack-op bundle between the pipeline and the register file.
// master = decode/ALU side, slave = register file.
interface regfile_2r1w_sp_if
  import regfile_2r1w_sp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_data;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
  logic              we;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  sp_op_e            sp_op;
  logic [DATA_W-1:0] sp_out;
  logic              sp_err;

  modport master (
    output ra_addr, rb_addr, we, wa_addr, wa_data, sp_op,
    input  ra_data, rb_data, sp_out, sp_err
  );

  modport slave (
    input  ra_addr, rb_addr, we, wa_addr, wa_data, sp_op,
    output ra_data, rb_data, sp_out, sp_err
  );

endinterface

// File: rtl/regfile_2r1w_sp_sp_ctrl.sv
// Stack-pointer next-state logic: decides the adjusted SP, whether a bound
// violation sets the error flag, and whether an explicit SP write overrides the op.
module regfile_2r1w_sp_sp_ctrl
  import regfile_2r1w_sp_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                SP_IDX   = DEF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_RESET = DEF_SP_RESET,
  parameter logic [DATA_W-1:0] SP_LIMIT = DEF_SP_LIMIT
) (
  input  logic [DATA_W-1:0] sp_cur,
  input  sp_op_e            sp_op,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa_addr,
  output logic [DATA_W-1:0] sp_next,
  output logic              sp_load,
  output logic              err_set,
  output logic              op_discard
);

  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);

  // An explicit write to the SP register takes priority over push/pop.
  assign op_discard = we && (wa_addr == SP_ADDR) &&
                      ((sp_op == SP_PUSH) || (sp_op == SP_POP));

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sp_next = sp_cur;
    sp_load = 1'b0;
    err_set = 1'b0;
    if (!op_discard) begin
      case (sp_op)
        SP_PUSH: begin
          if (sp_cur == SP_LIMIT) begin
            err_set = 1'b1;
          end else begin
            sp_next = sp_cur - 1'b1;
            sp_load = 1'b1;
          end
        end
        SP_POP: begin
          if (sp_cur == SP_RESET) begin
            err_set = 1'b1;
          end else begin
            sp_next = sp_cur + 1'b1;
            sp_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_2r1w_sp.sv
// Register file: two combinational read ports with write-through bypass, one
// synchronous write port, optional zero register and an auto-adjusting stack pointer.
module regfile_2r1w_sp
  import regfile_2r1w_sp_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                SP_IDX   = DEF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_RESET = DEF_SP_RESET,
  parameter logic [DATA_W-1:0] SP_LIMIT = DEF_SP_LIMIT,
  parameter bit                ZERO_R0  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  regfile_2r1w_sp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (ZERO_R0 && (SP_IDX == 0)) begin : g_bad_sp_idx
    $error("SP_IDX must not be 0 when ZERO_R0 is set");
  end
  if ((SP_IDX < 0) || (SP_IDX >= DEPTH)) begin : g_sp_idx_range
    $error("SP_IDX outside the register array");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic              sp_err_q;
  logic              wr_en;
  logic [DATA_W-1:0] sp_next;
  logic              sp_load;
  logic              err_set;
  logic              op_discard;

  assign wr_en = bus.we && !(ZERO_R0 && (bus.wa_addr == '0));

  regfile_2r1w_sp_sp_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SP_IDX   (SP_IDX),
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_ctrl (
    .sp_cur     (regs[SP_IDX]),
    .sp_op      (bus.sp_op),
    .we         (bus.we),
    .wa_addr    (bus.wa_addr),
    .sp_next    (sp_next),
    .sp_load    (sp_load),
    .err_set    (err_set),
    .op_discard (op_discard)
  );

  // NOTE: the array is built from flops rather than a RAM macro, because the
  // whole file must clear on reset; a RAM could not be reset this way.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, so the SP adjust and the write never see each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      sp_err_q <= 1'b0;
    end else begin
      if (sp_load) begin
        regs[SP_IDX] <= sp_next;
      end
      if (wr_en) begin
        regs[bus.wa_addr] <= bus.wa_data;
      end
      if (err_set && !op_discard) begin
        sp_err_q <= 1'b1;
      end
    end
  end

  // Register 0 short-circuits before the bypass so a write to it is never visible.
  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] stored,
                                                 input logic              we,
                                                 input logic [ADDR_W-1:0] wa_addr,
                                                 input logic [DATA_W-1:0] wa_data);
    if (ZERO_R0 && (addr == '0)) begin
      return '0;
    end else if (we && (addr == wa_addr)) begin
      return wa_data;
    end else begin
      return stored;
    end
  endfunction

  always_comb begin
    bus.ra_data = read_mux(bus.ra_addr, regs[bus.ra_addr], bus.we, bus.wa_addr, bus.wa_data);
    bus.rb_data = read_mux(bus.rb_addr, regs[bus.rb_addr], bus.we, bus.wa_addr, bus.wa_data);
  end

  assign bus.sp_out = regs[SP_IDX];
  assign bus.sp_err = sp_err_q;

endmodule

// File: tb/tb_regfile_2r1w_sp.sv
// Self-checking bench for regfile_2r1w_sp: directed vectors with literal
// expectations plus a per-cycle comparison against an array model.
module tb_regfile_2r1w_sp;
  import regfile_2r1w_sp_pkg::*;

  localparam int SP = 29;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  regfile_2r1w_sp_if bus ();

  regfile_2r1w_sp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic check_en = 1'b0;

  // Reference model: a plain array of register values and the error flag.
  logic [7:0] mdl [32];
  logic       mdl_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] <= 8'h00;
      mdl[SP] <= 8'hFF;
      mdl_err <= 1'b0;
    end else begin
      if (!(bus.we && bus.wa_addr == 5'(SP))) begin
        if (bus.sp_op == SP_PUSH) begin
          if (mdl[SP] == 8'h00) mdl_err <= 1'b1;
          else                  mdl[SP] <= mdl[SP] - 8'd1;
        end else if (bus.sp_op == SP_POP) begin
          if (mdl[SP] == 8'hFF) mdl_err <= 1'b1;
          else                  mdl[SP] <= mdl[SP] + 8'd1;
        end
      end
      if (bus.we && bus.wa_addr != 5'd0) mdl[bus.wa_addr] <= bus.wa_data;
    end
  end

  function automatic logic [7:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0)                      return 8'h00;
    if (bus.we && addr == bus.wa_addr)     return bus.wa_data;
    return mdl[addr];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_ra_data", 32'(bus.ra_data), 32'(exp_read(bus.ra_addr)));
      check("cyc_rb_data", 32'(bus.rb_data), 32'(exp_read(bus.rb_addr)));
      check("cyc_sp_out",  32'(bus.sp_out),  32'(mdl[SP]));
      check("cyc_sp_err",  32'(bus.sp_err),  32'(mdl_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                       input sp_op_e op, input logic [4:0] ra, input logic [4:0] rb);
    bus.we      = w;
    bus.wa_addr = wa;
    bus.wa_data = wd;
    bus.sp_op   = op;
    bus.ra_addr = ra;
    bus.rb_addr = rb;
    #1;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'd0, 5'd0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.we = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.sp_op = SP_NONE; bus.ra_addr = '0; bus.rb_addr = '0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    check_en = 1'b1;
    check("rst_sp_out", 32'(bus.sp_out), 32'h0000_00FF);
    check("rst_sp_err", 32'(bus.sp_err), 32'h0);

    // Reset contents on both ports.
    for (int i = 0; i < 32; i++) begin
      tick();
      drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'(i), 5'(31 - i));
      check("rst_ra", 32'(bus.ra_data), (i == 29) ? 32'hFF : 32'h0);
      check("rst_rb", 32'(bus.rb_data), ((31 - i) == 29) ? 32'hFF : 32'h0);
    end

    // Write-through bypass then committed value.
    tick();
    drive(1'b1, 5'd5, 8'hA5, SP_NONE, 5'd5, 5'd5);
    check("bypass_ra", 32'(bus.ra_data), 32'hA5);
    check("bypass_rb", 32'(bus.rb_data), 32'hA5);
    tick();
    drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'd5, 5'd5);
    check("commit_ra", 32'(bus.ra_data), 32'hA5);

    // Register 0 is hardwired to zero.
    drive(1'b1, 5'd0, 8'h3C, SP_NONE, 5'd0, 5'd0);
    check("r0_during", 32'(bus.ra_data), 32'h0);
    tick();
    drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'd0, 5'd0);
    check("r0_after", 32'(bus.ra_data), 32'h0);

    // Three pushes, four pops; last pop underflows.
    drive(1'b0, 5'd0, 8'h00, SP_PUSH, 5'd29, 5'd0);
    tick(); check("push1", 32'(bus.sp_out), 32'hFE);
    tick(); check("push2", 32'(bus.sp_out), 32'hFD);
    drive(1'b0, 5'd0, 8'h00, SP_PUSH, 5'd29, 5'd0);
    tick(); check("push3", 32'(bus.sp_out), 32'hFC);
    drive(1'b0, 5'd0, 8'h00, SP_POP, 5'd29, 5'd0);
    tick(); check("pop1", 32'(bus.sp_out), 32'hFD);
    tick(); check("pop2", 32'(bus.sp_out), 32'hFE);
    tick(); check("pop3", 32'(bus.sp_out), 32'hFF);
    check("pop3_err", 32'(bus.sp_err), 32'h0);
    tick(); check("pop4", 32'(bus.sp_out), 32'hFF);
    check("pop4_err", 32'(bus.sp_err), 32'h1);
    drive(1'b0, 5'd0, 8'h00, SP_PUSH, 5'd29, 5'd0);
    tick(); check("err_sticky_sp", 32'(bus.sp_out), 32'hFE);
    drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'd29, 5'd0);
    tick(); tick(); check("err_sticky", 32'(bus.sp_err), 32'h1);

    // Overflow at the lower limit.
    pulse_reset();
    check("rst2_err", 32'(bus.sp_err), 32'h0);
    tick();
    drive(1'b1, 5'd29, 8'h00, SP_NONE, 5'd29, 5'd0);
    tick(); check("sp_wr0", 32'(bus.sp_out), 32'h00);
    drive(1'b0, 5'd0, 8'h00, SP_PUSH, 5'd29, 5'd0);
    tick(); check("limit_sp", 32'(bus.sp_out), 32'h00);
    check("limit_err", 32'(bus.sp_err), 32'h1);

    // Explicit SP write beats a simultaneous push; reserved op is a no-op.
    pulse_reset();
    tick();
    drive(1'b1, 5'd29, 8'h80, SP_PUSH, 5'd29, 5'd29);
    tick(); check("wr_wins_sp", 32'(bus.sp_out), 32'h80);
    check("wr_wins_err", 32'(bus.sp_err), 32'h0);
    drive(1'b0, 5'd0, 8'h00, SP_RSVD, 5'd29, 5'd0);
    tick(); check("rsvd_sp", 32'(bus.sp_out), 32'h80);

    // Asynchronous reset between edges.
    drive(1'b1, 5'd29, 8'hFF, SP_NONE, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 8'h00, SP_POP, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd29, 8'h10, SP_NONE, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 8'h77, SP_NONE, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'd7, 5'd29);
    check("pre_rst_sp", 32'(bus.sp_out), 32'h10);
    check("pre_rst_err", 32'(bus.sp_err), 32'h1);
    check("pre_rst_r7", 32'(bus.ra_data), 32'h77);
    reset = 1'b1;
    #1;
    check("async_rst_sp", 32'(bus.sp_out), 32'hFF);
    check("async_rst_err", 32'(bus.sp_err), 32'h0);
    check("async_rst_r7", 32'(bus.ra_data), 32'h0);
    reset = 1'b0;

    // Mixed traffic checked against the model every cycle.
    for (int i = 1; i < 32; i++) begin
      tick();
      drive(1'b1, 5'(i), 8'(i * 7 + 3), sp_op_e'(2'(i % 4)), 5'(i), 5'(i - 1));
    end
    tick();
    drive(1'b0, 5'd0, 8'h00, SP_NONE, 5'd12, 5'd29);
    check("mix_r12", 32'(bus.ra_data), 32'(8'(12 * 7 + 3)));
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_sp.md
Name: regfile_2r1w_sp

Overview:
- Parametrised successor to the single-port 8-bit, 32-entry register file.
- Two asynchronous read ports and one synchronous write port, with write-through bypass on both read ports.
- Optional hardwired zero register.
- Dedicated stack-pointer register with push/pop auto-adjust, bound checking and a sticky error flag.
- Sits between decode (register addresses) and ALU/memory stage (operands, write-back, stack ops).

Parameters:
DATA_W, 8, data width of every register
ADDR_W, 5, address width; depth = 2**ADDR_W
SP_IDX, 29, index of stack-pointer register
SP_RESET, 8'hFF, stack-pointer reset value (top of stack); width DATA_W
SP_LIMIT, 8'h00, lowest legal stack-pointer value; push below this is an error
ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ra_addr  input  ADDR_W  read port A address
ra_data  output  DATA_W  read port A data (combinational)
rb_addr  input  ADDR_W  read port B address
rb_data  output  DATA_W  read port B data (combinational)
we  input  1  write enable
wa_addr  input  ADDR_W  write address
wa_data  input  DATA_W  write data
sp_op  input  2  00 none, 01 push (SP-1), 10 pop (SP+1), 11 reserved (treated as none)
sp_out  output  DATA_W  current SP register value (combinational from state)
sp_err  output  1  sticky stack over/underflow flag (registered)

Behaviour:
- Reset (asynchronous, active-high; any time, including mid-operation):
  - All registers cleared to 0; register SP_IDX = SP_RESET; sp_err = 0.
  - While reset is high, writes and sp_op are ignored.
- Reads are combinational, zero latency.
  - Data = stored value, except bypass: if we=1 and ra_addr==wa_addr, ra_data = wa_data (same for port B).
  - ZERO_R0=1 and address 0: read returns 0, no bypass.
  - Both ports may read the same address; results are identical.
- Write: on rising clk with we=1, reg[wa_addr] <= wa_data.
  - Ignored when ZERO_R0=1 and wa_addr=0.
- Stack ops, applied on rising clk, evaluated on pre-edge SP:
  - Push: SP==SP_LIMIT -> SP unchanged, sp_err<=1; else SP<=SP-1.
  - Pop: SP==SP_RESET -> SP unchanged, sp_err<=1; else SP<=SP+1.
  - Arithmetic is DATA_W modulo, but the bounds above prevent wrap.
  - Bypass does not apply to sp_op: reads of SP_IDX see the pre-edge value.
- Write to SP_IDX in the same cycle as a push/pop: explicit write wins, sp_op is discarded, sp_err is unchanged.
- sp_err stays set until reset; it has no other clear.
- sp_out always equals reg[SP_IDX] and updates one edge after a push, pop or write.
- Single always-block register array; no latches. SP_IDX must not be 0 when ZERO_R0=1 (elaboration-time check).

Decomposition:
- Shared package: sp_op encodings (SP_NONE, SP_PUSH, SP_POP), default DATA_W/ADDR_W, default SP_IDX/SP_RESET.
- One natural sub-module: sp_ctrl. It computes next-SP, sp_err set and the "sp_op discarded" condition from the current SP, sp_op, we and wa_addr.
- The array and bypass muxes stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on both ports -> 0 everywhere except addr 29 = 8'hFF; sp_err=0.
- we=1, wa_addr=5, wa_data=8'hA5, ra_addr=5 in the same cycle -> ra_data=8'hA5 before the edge (bypass); after the edge with we=0, ra_data=8'hA5.
- Write 8'h3C to addr 0 with ZERO_R0=1 -> ra_data=0 both during the cycle and after the edge.
- Three pushes from reset -> sp_out 8'hFE, 8'hFD, 8'hFC; four pops -> 8'hFD, 8'hFE, 8'hFF, then 8'hFF with sp_err=1, which stays 1 until reset.
- Write SP_IDX=8'h00, then push -> SP stays 8'h00, sp_err=1.
- Same cycle: we=1, wa_addr=29, wa_data=8'h80, sp_op=push -> SP=8'h80, sp_err=0.
- Assert reset mid-sequence (SP=8'h10, sp_err=1) between clock edges -> SP=8'hFF and sp_err=0 immediately, without a clock edge.
